// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: MEM-priority IF/MEM arbiter for one single-port RAM; define PIPE_ARB_TIMEOUT_EN for the 16-cycle wait timeout.
module pipe_mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        arb_err
);
  localparam logic [1:0] IDLE = 2'd0, D_WAIT = 2'd1, I_WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [3:0] cnt;
  logic timeout;
  logic [31:0] rdata_in;
`ifdef PIPE_ARB_TIMEOUT_EN
  assign timeout = ~ram_ack && cnt == 4'd15;
`else
  assign timeout = 1'b0;
`endif
  assign rdata_in = ram_ack ? ram_rdata : '0;
  assign stall_if = if_req & ~if_ready;
  assign stall_mem = (mem_rd | mem_wr) & ~mem_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      arb_err <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_rd | mem_wr) begin
            state <= D_WAIT;
            ram_en <= 1'b1;
            ram_we <= mem_wr;
            ram_addr <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (if_req) begin
            state <= I_WAIT;
            ram_en <= 1'b1;
            ram_we <= 1'b0;
            ram_addr <= if_addr;
            ram_wdata <= '0;
          end
        end
        RESP: state <= IDLE;
        default: begin
          if (ram_ack | timeout) begin
            state <= RESP;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            arb_err <= arb_err | timeout;
            if (state == I_WAIT) begin
              if_rdata <= rdata_in;
              if_ready <= 1'b1;
            end else begin
              mem_ready <= 1'b1;
              if (!ram_we) mem_rdata <= rdata_in;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed and randomized checks of pipe_mem_arbiter against a transaction-level model.
module tb_pipe_mem_arbiter;
  logic clock = 1'b0;
  logic reset, if_req, if_ready, mem_rd, mem_wr, mem_ready, stall_if, stall_mem;
  logic ram_en, ram_we, ram_ack, arb_err;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  int vectors = 0, miscompares = 0, ack_delay = 0, wcnt = 0;
  logic [31:0] rd_val = '0;
  bit spurious = 1'b0;
  logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0;
  logic exp_arb_err = 1'b0;

  always #5 clock = ~clock;

  pipe_mem_arbiter dut (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_if(stall_if),
    .stall_mem(stall_mem), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack), .arb_err(arb_err)
  );

  // Memory responder: acks ack_delay cycles into an access; optional random acks while idle.
  task automatic tick();
    @(negedge clock);
    if (ram_en) begin
      ram_ack = (wcnt >= ack_delay);
      ram_rdata = ram_ack ? rd_val : $urandom;
      wcnt++;
    end else begin
      wcnt = 0;
      ram_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      ram_rdata = $urandom;
    end
  endtask

  task automatic do_access(input bit is_mem, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit we, input int d, input logic [31:0] rdata);
    int n, exp_n;
    bit timed;
    logic [31:0] exp_wd;
    exp_wd = is_mem ? wdata : 32'd0;
    exp_n = d + 1;
`ifdef PIPE_ARB_TIMEOUT_EN
    if (d >= 16) exp_n = 16;
`endif
    timed = (exp_n != d + 1);
    ack_delay = d;
    rd_val = rdata;
    tick();
    vectors++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, we, addr, exp_wd}) begin
      miscompares++;
      $display("FAIL issue: got en=%b we=%b addr=%h wdata=%h, want en=1 we=%b addr=%h wdata=%h",
               ram_en, ram_we, ram_addr, ram_wdata, we, addr, exp_wd);
    end
    n = 0;
    while (!(is_mem ? mem_ready : if_ready) && n < 40) begin
      vectors++;
      if ({ram_en, ram_we, (is_mem ? stall_mem : stall_if)} !== {1'b1, we, 1'b1}) begin
        miscompares++;
        $display("FAIL wait_hold: got en=%b we=%b stall=%b, want en=1 we=%b stall=1",
                 ram_en, ram_we, (is_mem ? stall_mem : stall_if), we);
      end
      tick();
      n++;
    end
    vectors++;
    if (n !== exp_n) begin
      miscompares++;
      $display("FAIL latency: got %0d wait cycles, want %0d", n, exp_n);
    end
    if (is_mem) begin
      if (!we) exp_mem_rdata = timed ? 32'd0 : rdata;
    end else exp_if_rdata = timed ? 32'd0 : rdata;
    if (timed) exp_arb_err = 1'b1;
    vectors++;
    if ({ram_en, ram_we, if_ready, mem_ready, (is_mem ? stall_mem : stall_if)} !== {2'b00, !is_mem, is_mem, 1'b0}) begin
      miscompares++;
      $display("FAIL resp: got en=%b we=%b if_ready=%b mem_ready=%b stall=%b, want 0 0 %b %b 0",
               ram_en, ram_we, if_ready, mem_ready, (is_mem ? stall_mem : stall_if), !is_mem, is_mem);
    end
    vectors++;
    if ({if_rdata, mem_rdata, arb_err} !== {exp_if_rdata, exp_mem_rdata, exp_arb_err}) begin
      miscompares++;
      $display("FAIL rdata: got if=%h mem=%h err=%b, want if=%h mem=%h err=%b",
               if_rdata, mem_rdata, arb_err, exp_if_rdata, exp_mem_rdata, exp_arb_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {if_req, mem_rd, mem_wr, ram_ack} = '0;
    {if_addr, mem_addr, mem_wdata, ram_rdata} = '0;
    spurious = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_if_rdata = '0;
    exp_mem_rdata = '0;
    exp_arb_err = 1'b0;
    vectors++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_ready, mem_ready, arb_err, stall_if, stall_mem} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wdata=%h if=%h mem=%h rdy=%b%b err=%b, want all 0",
               ram_en, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_ready, mem_ready, arb_err);
    end
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    do_access(1'b0, 32'h40, 32'h0, 1'b0, 0, 32'h8C22_0004);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1;
    if_addr = 32'h0000_0300;
    mem_rd = 1'b1;
    mem_addr = 32'h0000_0100;
    do_access(1'b1, 32'h100, mem_wdata, 1'b0, 1, 32'h1234_5678);
    mem_rd = 1'b0;
    tick();
    vectors++;
    if ({ram_en, stall_if} !== 2'b01) begin
      miscompares++;
      $display("FAIL simul_gap: got en=%b stall_if=%b, want en=0 stall_if=1", ram_en, stall_if);
    end
    do_access(1'b0, 32'h300, 32'h0, 1'b0, 2, 32'hCAFE_0001);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    mem_wr = 1'b1;
    mem_addr = 32'h0000_0200;
    mem_wdata = 32'hDEAD_BEEF;
    do_access(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 4, 32'h5555_AAAA);
    mem_wr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_rd = 1'b1;
    mem_addr = 32'h0000_0400;
    ack_delay = 1000;
    tick();
    reset = 1'b1;
    ram_ack = 1'b1;
    ram_rdata = 32'h1357_9BDF;
    @(negedge clock);
    reset = 1'b0;
    mem_rd = 1'b0;
    exp_if_rdata = '0;
    exp_mem_rdata = '0;
    exp_arb_err = 1'b0;
    vectors++;
    if ({ram_en, mem_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid: got en=%b mem_ready=%b, want 0 0", ram_en, mem_ready);
    end
    @(negedge clock);
    vectors++;
    if ({ram_en, mem_ready, mem_rdata} !== {2'b00, 32'd0}) begin
      miscompares++;
      $display("FAIL late_ack: got en=%b mem_ready=%b mem_rdata=%h, want 0 0 0", ram_en, mem_ready, mem_rdata);
    end
    ram_ack = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h0000_0044;
    do_access(1'b0, 32'h44, 32'h0, 1'b0, 0, 32'h0BAD_F00D);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    mem_rd = 1'b1;
    mem_addr = 32'h0000_0500;
`ifdef PIPE_ARB_TIMEOUT_EN
    do_access(1'b1, 32'h500, mem_wdata, 1'b0, 1000, 32'hFFFF_FFFF);
    mem_rd = 1'b0;
    tick();
    if_req = 1'b1;
    if_addr = 32'h0000_0048;
    do_access(1'b0, 32'h48, 32'h0, 1'b0, 1, 32'h2468_ACE0);
    if_req = 1'b0;
    tick();
`else
    ack_delay = 1000;
    for (int k = 0; k < 30; k++) begin
      tick();
      vectors++;
      if ({ram_en, stall_mem, mem_ready, arb_err} !== 4'b1100) begin
        miscompares++;
        $display("FAIL no_timeout: got en=%b stall_mem=%b mem_ready=%b err=%b, want 1 1 0 0",
                 ram_en, stall_mem, mem_ready, arb_err);
      end
    end
    reset = 1'b1;
    mem_rd = 1'b0;
    tick();
    reset = 1'b0;
    exp_if_rdata = '0;
    exp_mem_rdata = '0;
    exp_arb_err = 1'b0;
    tick();
`endif
  endtask

  task automatic test_random();
    int m, d1, d2;
    bit i;
    logic [31:0] ia, ma, mw, r1, r2;
    spurious = 1'b1;
    for (int k = 0; k < 80; k++) begin
      m = $urandom_range(0, 3);
      i = 1'($urandom_range(0, 1));
      d1 = $urandom_range(0, 7);
      d2 = $urandom_range(0, 7);
      ia = $urandom;
      ma = $urandom;
      mw = $urandom;
      r1 = $urandom;
      r2 = $urandom;
      if_req = i;
      if_addr = ia;
      mem_rd = (m == 1 || m == 3);
      mem_wr = (m >= 2);
      mem_addr = ma;
      mem_wdata = mw;
      if (m != 0) begin
        do_access(1'b1, ma, mw, mem_wr, d1, r1);
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        tick();
        vectors++;
        if ({ram_en, stall_if} !== {1'b0, i}) begin
          miscompares++;
          $display("FAIL rand_gap: got en=%b stall_if=%b, want 0 %b", ram_en, stall_if, i);
        end
      end
      if (i) begin
        do_access(1'b0, ia, 32'h0, 1'b0, d2, r2);
        if_req = 1'b0;
        tick();
      end
      if (m == 0 && !i) begin
        tick();
        vectors++;
        if ({ram_en, if_ready, mem_ready} !== 3'b000) begin
          miscompares++;
          $display("FAIL rand_idle: got en=%b if_ready=%b mem_ready=%b, want 000", ram_en, if_ready, mem_ready);
        end
      end
    end
    spurious = 1'b0;
  endtask

  task automatic test_final_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({arb_err, if_rdata, mem_rdata} !== '0) begin
      miscompares++;
      $display("FAIL final_reset: got err=%b if=%h mem=%h, want 0 0 0", arb_err, if_rdata, mem_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_reset_mid();
    test_timeout();
    test_random();
    test_final_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
